// File: rtl/sram_sp_param.sv
// Parametrised single-port SRAM built from flops, with byte enables, a valid/ready
// request port, a registered read response and an optional zero-fill after reset.
module sram_sp_param #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned ADDR_W        = $clog2(DEPTH),
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  input  logic [WIDTH/8-1:0]   req_be,
  output logic                 rsp_valid,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic                 init_done
);

  localparam int unsigned       NumBytes = WIDTH / 8;
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                rd_pend_q;
  logic                rd_oor_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [WIDTH-1:0]    mem [DEPTH];

  logic addr_ok;
  logic accept;
  logic wr_en;
  logic rd_en;
  logic init_wr;

  // Only reachable when DEPTH is not a power of two.
  assign addr_ok = {1'b0, req_addr} < DepthW;
  assign accept  = req_valid && req_ready;
  assign wr_en   = accept && req_write && addr_ok;
  assign rd_en   = accept && !req_write;
  assign init_wr = (state_q == StInit) && INIT_ON_RESET;

  // Storage is deliberately left without a reset.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (req_be[b]) begin
          mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_oor_q  <= 1'b0;
      rd_addr_q <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // A read accepted on the previous edge is delivered now; the array has not
      // yet seen any later write, so the data reflects the state at acceptance.
      rsp_valid <= rd_pend_q;
      if (rd_pend_q) begin
        rsp_rdata <= rd_oor_q ? '0 : mem[rd_addr_q];
      end
      rd_pend_q <= 1'b0;

      case (state_q)
        StInit: begin
          if (!INIT_ON_RESET || (cnt_q == LastAddr)) begin
            state_q   <= StRun;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        StRun: begin
          if (rd_en) begin
            rd_pend_q <= 1'b1;
            rd_addr_q <= req_addr;
            rd_oor_q  <= !addr_ok;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule
